// File: rtl/trdb_packet_emitter.sv
// E-Trace packet emitter: buffers complete packets in a small FIFO and serialises each as one header byte plus 0..4 payload bytes.
// Optional TRDB_EMIT_STATS_EN adds pkt_count_o (completed packets, saturating) and stall_o (registered input-stall flag).
module trdb_packet_emitter #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PAYLOAD_LEN = 31
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          pkt_valid_i,
    output logic                          pkt_ready_o,
    input  logic [1:0]                    format_i,
    input  logic [1:0]                    subformat_i,
    input  logic [PAYLOAD_LEN-1:0]        payload_i,
    input  logic [2:0]                    plen_i,
    output logic [7:0]                    byte_o,
    output logic                          byte_valid_o,
    input  logic                          byte_ready_i,
    output logic                          last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef TRDB_EMIT_STATS_EN
    ,
    output logic [15:0]                   pkt_count_o,
    output logic                          stall_o
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [1:0]  sub;
        logic [31:0] pld;
        logic [2:0]  plen;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        wr_entry;
    entry_t        hold_q, hold_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count;
    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic          full, empty, push;
    logic [7:0]    pld_byte;

    // Pointers carry a wrap bit, so their difference is the occupancy directly.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == PW'(FIFO_DEPTH));
    assign empty        = (count == '0);
    assign pkt_ready_o  = !full;
    assign fifo_count_o = count;
    assign push         = pkt_valid_i && !full && !flush_i;

    always_comb begin
        wr_entry      = '0;
        wr_entry.fmt  = format_i;
        wr_entry.sub  = subformat_i;
        wr_entry.pld  = 32'(payload_i);
        wr_entry.plen = (plen_i > 3'd4) ? 3'd4 : plen_i;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // Payload is zero-extended to 32 bits at write, so the top bit of byte 3 reads as 0.
    assign pld_byte = 8'(hold_q.pld >> {idx_q, 3'b000});

    always_comb begin
        byte_valid_o = 1'b0;
        byte_o       = '0;
        last_o       = 1'b0;
        case (state_q)
            HDR: begin
                byte_valid_o = 1'b1;
                byte_o       = {hold_q.fmt, hold_q.sub, 1'b0, hold_q.plen};
                last_o       = (hold_q.plen == 3'd0);
            end
            PLD: begin
                byte_valid_o = 1'b1;
                byte_o       = pld_byte;
                last_o       = ({1'b0, idx_q} == (hold_q.plen - 3'd1));
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    hold_d   = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (byte_ready_i) begin
                    if (hold_q.plen == 3'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PLD;
                        idx_d   = 2'd0;
                    end
                end
            end
            PLD: begin
                if (byte_ready_i) begin
                    if (last_o) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush drops both the queued packets and the one being serialised.
        if (flush_i) begin
            state_d  = IDLE;
            idx_d    = 2'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef TRDB_EMIT_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        stall_q, stall_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (byte_valid_o && byte_ready_i && last_o && (pkt_count_q != 16'hFFFF)) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
        stall_d = pkt_valid_i && !pkt_ready_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_count_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            pkt_count_q <= pkt_count_d;
            stall_q     <= stall_d;
        end
    end

    assign pkt_count_o = pkt_count_q;
    assign stall_o     = stall_q;
`endif

endmodule

// File: tb/tb_trdb_packet_emitter.sv
// Self-checking bench for trdb_packet_emitter: directed scenarios plus random traffic against a byte-stream scoreboard.
// Define TRDB_EMIT_STATS_EN to also exercise pkt_count_o and stall_o.
module tb_trdb_packet_emitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [1:0]  fmt = '0;
    logic [1:0]  sub = '0;
    logic [30:0] payload = '0;
    logic [2:0]  plen = '0;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        last;
    logic [2:0]  fifo_count;
`ifdef TRDB_EMIT_STATS_EN
    logic [15:0] pkt_count;
    logic        stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];   // expected {last, byte} stream
    logic [8:0] got_q[$];

    logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_flush = 1'b0, p_rst = 1'b0;
    logic [7:0] p_byte = '0;

    trdb_packet_emitter #(.FIFO_DEPTH(4), .PAYLOAD_LEN(31)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .pkt_valid_i  (pkt_valid),
        .pkt_ready_o  (pkt_ready),
        .format_i     (fmt),
        .subformat_i  (sub),
        .payload_i    (payload),
        .plen_i       (plen),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .last_o       (last),
        .fifo_count_o (fifo_count)
`ifdef TRDB_EMIT_STATS_EN
        ,
        .pkt_count_o  (pkt_count),
        .stall_o      (stall)
`endif
    );

    always #5 clk = ~clk;

    // A packet becomes its header byte followed by the low plen bytes of the payload.
    function automatic void model_push(input logic [1:0] f, input logic [1:0] s,
                                       input logic [30:0] p, input logic [2:0] l);
        int n;
        logic [31:0] w;
        n = (l > 3'd4) ? 4 : int'(l);
        w = {1'b0, p};
        exp_q.push_back({(n == 0), f, s, 1'b0, 3'(n)});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), w[8*i +: 8]});
        end
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (p_rst && p_valid && !p_ready && !p_flush) begin
                n_checks++;
                if ({byte_valid, last, byte_o} !== {1'b1, p_last, p_byte}) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b last=%0b byte=%02h, required v=1 last=%0b byte=%02h",
                             byte_valid, last, byte_o, p_last, p_byte);
                end
            end
            if (byte_valid && byte_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got byte %02h last %0b, required no byte", byte_o, last);
                end else begin
                    e = exp_q.pop_front();
                    if ({last, byte_o} !== e) begin
                        n_fail++;
                        $display("FAIL sb_byte: got last=%0b byte=%02h, required last=%0b byte=%02h",
                                 last, byte_o, e[8], e[7:0]);
                    end
                end
            end
            if (flush) exp_q.delete();
            else if (pkt_valid && pkt_ready) model_push(fmt, sub, payload, plen);
        end
        p_valid <= byte_valid;
        p_ready <= byte_ready;
        p_last  <= last;
        p_byte  <= byte_o;
        p_flush <= flush;
        p_rst   <= rst_n;
    end

    task automatic send_pkt(input logic [1:0] f, input logic [1:0] s, input logic [30:0] p, input logic [2:0] l);
        int t;
        fmt = f; sub = s; payload = p; plen = l; pkt_valid = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (pkt_ready) break;
        end
        n_checks++;
        if (t == 200) begin n_fail++; $display("FAIL send_timeout: got ready=%0b, required 1", pkt_ready); end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        $display("send fmt=%0d sub=%0d payload=%08h plen=%0d", f, s, p, l);
    endtask

    task automatic collect(input int n);
        int t;
        got_q.delete();
        for (t = 0; t < 400 && got_q.size() < n; t++) begin
            @(negedge clk);
            if (byte_valid && byte_ready) got_q.push_back({last, byte_o});
        end
        n_checks++;
        if (got_q.size() != n) begin n_fail++; $display("FAIL collect_timeout: got %0d bytes, required %0d", got_q.size(), n); end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !byte_valid && fifo_count == 3'd0) break;
        end
        n_checks++;
        if (t == 400) begin n_fail++; $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", byte_valid); end
        if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b, required 0", last); end
        if (byte_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %02h, required 00", byte_o); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        if (pkt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b, required 1", pkt_ready); end
`ifdef TRDB_EMIT_STATS_EN
        n_checks += 2;
        if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d, required 0", pkt_count); end
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b, required 0", stall); end
`endif
        $display("reset checked");
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [8:0] exp_b [5] = '{9'h0C4, 9'h078, 9'h056, 9'h034, 9'h112};
        byte_ready = 1'b1;
        send_pkt(2'd3, 2'd0, 31'h12345678, 3'd4);
        @(negedge clk);
        n_checks++;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_cycle: got valid=%0b, required 0", byte_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({byte_valid, last, byte_o} !== {1'b1, exp_b[i]}) begin
                n_fail++;
                $display("FAIL single_byte%0d: got v=%0b last=%0b byte=%02h, required v=1 last=%0b byte=%02h",
                         i, byte_valid, last, byte_o, exp_b[i][8], exp_b[i][7:0]);
            end
        end
        $display("single packet checked");
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_plen_edges();
        logic [8:0] exp_b [5] = '{9'h064, 9'h00D, 9'h00C, 9'h00B, 9'h10A};
        byte_ready = 1'b1;
        send_pkt(2'd2, 2'd0, 31'($urandom), 3'd0);
        collect(1);
        n_checks++;
        if (got_q[0] !== 9'h180) begin n_fail++; $display("FAIL plen0_hdr: got %03h, required 180", got_q[0]); end
        send_pkt(2'd1, 2'd2, 31'h0A0B0C0D, 3'd7);
        collect(5);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL plen7_byte%0d: got %03h, required %03h", i, got_q[i], exp_b[i]); end
        end
        $display("plen edge cases checked");
        drain();
    endtask

    task automatic test_backpressure();
        logic [8:0] exp_b [4] = '{9'h0CC, 9'h033, 9'h0AA, 9'h155};
        int t;
        byte_ready = 1'b1;
        send_pkt(2'd3, 2'd1, 31'h55AA33CC, 3'd4);
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (byte_valid) break;
        end
        @(posedge clk); #1;
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({byte_valid, last, byte_o} !== {1'b1, 1'b0, 8'hCC}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%0b last=%0b byte=%02h, required v=1 last=0 byte=cc", i, byte_valid, last, byte_o);
            end
        end
        @(posedge clk); #1;
        byte_ready = 1'b1;
        collect(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %03h, required %03h", i, got_q[i], exp_b[i]); end
        end
        $display("backpressure checked");
        drain();
    endtask

    task automatic test_fifo_full();
        int t;
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_pkt(2'($urandom), 2'($urandom), 31'($urandom), 3'd1);
        @(negedge clk);
        n_checks += 2;
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d, required 4", fifo_count); end
        if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b, required 0", pkt_ready); end
        @(posedge clk); #1;
        fmt = 2'd1; sub = 2'd1; payload = 31'($urandom); plen = 3'd2; pkt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold%0d: got ready=%0b, required 0", i, pkt_ready); end
`ifdef TRDB_EMIT_STATS_EN
            if (i > 0) begin
                n_checks++;
                if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_flag%0d: got %0b, required 1", i, stall); end
            end
`endif
        end
        @(posedge clk); #1;
        byte_ready = 1'b1;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (pkt_ready) break;
        end
        n_checks += 2;
        if (t == 40) begin n_fail++; $display("FAIL full_recover: got ready=%0b, required 1", pkt_ready); end
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL full_recover_count: got %0d, required 3", fifo_count); end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        drain();
        $display("fifo full checked");
    endtask

    task automatic test_back_to_back();
        logic [7:0] vtr, ltr;
        vtr = '0; ltr = '0;
        byte_ready = 1'b0;
        send_pkt(2'd0, 2'd1, 31'($urandom), 3'd1);
        send_pkt(2'd1, 2'd2, 31'($urandom), 3'd2);
        send_pkt(2'd2, 2'd3, 31'($urandom), 3'd0);
        byte_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vtr[i] = byte_valid;
            ltr[i] = last;
        end
        n_checks += 3;
        if (vtr !== 8'hBB) begin n_fail++; $display("FAIL b2b_valid_trace: got %08b, required 10111011", vtr); end
        if (ltr !== 8'hA2) begin n_fail++; $display("FAIL b2b_last_trace: got %08b, required 10100010", ltr); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_count: got %0d, required 0", fifo_count); end
        @(posedge clk); #1;
        drain();
        $display("back-to-back checked");
    endtask

    task automatic test_flush();
        byte_ready = 1'b0;
        send_pkt(2'd3, 2'd0, 31'h44332211, 3'd4);
        send_pkt(2'd1, 2'd0, 31'($urandom), 3'd3);
        send_pkt(2'd2, 2'd1, 31'($urandom), 3'd2);
        byte_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (byte_o !== 8'h11) begin n_fail++; $display("FAIL flush_pre_idx0: got %02h, required 11", byte_o); end
        @(posedge clk); #1;
        flush = 1'b1;
        fmt = 2'd3; sub = 2'd3; payload = 31'($urandom); plen = 3'd4; pkt_valid = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (byte_o !== 8'h22) begin n_fail++; $display("FAIL flush_pre_idx1: got %02h, required 22", byte_o); end
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL flush_pre_count: got %0d, required 2", fifo_count); end
        @(posedge clk); #1;
        flush = 1'b0;
        pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid%0d: got %0b, required 0", i, byte_valid); end
            if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL flush_count%0d: got %0d, required 0", i, fifo_count); end
        end
        @(posedge clk); #1;
        send_pkt(2'd1, 2'd3, 31'h0000BEEF, 3'd2);
        collect(3);
        n_checks += 3;
        if (got_q[0] !== 9'h072) begin n_fail++; $display("FAIL post_flush_hdr: got %03h, required 072", got_q[0]); end
        if (got_q[1] !== 9'h0EF) begin n_fail++; $display("FAIL post_flush_b0: got %03h, required 0ef", got_q[1]); end
        if (got_q[2] !== 9'h1BE) begin n_fail++; $display("FAIL post_flush_b1: got %03h, required 1be", got_q[2]); end
        drain();
        $display("flush checked");
    endtask

    task automatic test_reset_mid();
        byte_ready = 1'b1;
        send_pkt(2'd3, 2'd2, 31'($urandom), 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b, required 0", byte_valid); end
        if (last !== 1'b0) begin n_fail++; $display("FAIL rstmid_last: got %0b, required 0", last); end
        if (byte_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_byte: got %02h, required 00", byte_o); end
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d, required 0", fifo_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_pkt(2'd0, 2'd1, 31'($urandom), 3'd0);
        collect(1);
        n_checks++;
        if (got_q[0] !== 9'h110) begin n_fail++; $display("FAIL rstmid_next: got %03h, required 110", got_q[0]); end
        drain();
        $display("reset mid-packet checked");
    endtask

`ifdef TRDB_EMIT_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        byte_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_pkt(2'($urandom), 2'($urandom), 31'($urandom), 3'($urandom_range(0, 4)));
        drain();
        n_checks++;
        if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL stats_three: got %0d, required 3", pkt_count); end
        send_pkt(2'd3, 2'd0, 31'($urandom), 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drain();
        n_checks++;
        if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL stats_flushed: got %0d, required 3", pkt_count); end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d, required 0", pkt_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("stats checked");
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            byte_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 59) == 0);
            pkt_valid  = ($urandom_range(0, 2) == 0);
            fmt        = 2'($urandom);
            sub        = 2'($urandom);
            payload    = 31'($urandom);
            plen       = 3'($urandom);
            @(posedge clk); #1;
        end
        pkt_valid  = 1'b0;
        flush      = 1'b0;
        byte_ready = 1'b1;
        drain();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_leftover: got %0d pending bytes, required 0", exp_q.size()); end
        $display("random traffic checked");
    endtask

    initial begin
        test_reset();
        test_single();
        test_plen_edges();
        test_backpressure();
        test_fifo_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef TRDB_EMIT_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
